msg_schedule_gen: RTL
=====================

// Module: msg_schedule_gen
// PURPOSE
//  SHA-256 message-schedule stage. Accepts one 512-bit padded block from the
//  hashComp/messageSplit path and streams W[0..ROUNDS-1], one word per
//  handshake, to the round datapath that consumes TemporaryWordOne/Two.
//  Built on a 16-word sliding window, so one schedule adder tree serves all rounds.
// PARAMETERS
//  ROUNDS    64   number of W words emitted per block (legal range 16..64)
//  BLOCK_W   512  input block width; fixed at 16 x 32-bit words
// PORTS
//  clk        in   1    rising-edge clock, single clock domain
//  rst        in   1    synchronous, active-low reset
//  blk_valid  in   1    blk_data holds a valid padded block
//  blk_ready  out  1    block accepted when blk_valid && blk_ready
//  blk_data   in   512  block; word 0 = blk_data[511:480], word 15 = [31:0]
//  w_valid    out  1    w_data/w_idx valid
//  w_ready    in   1    consumer takes word when w_valid && w_ready
//  w_data     out  32   schedule word W[w_idx]
//  w_idx      out  6    round index 0..ROUNDS-1
//  w_last     out  1    high with w_valid when w_idx == ROUNDS-1
//  busy       out  1    high from block accept until last word taken
// BEHAVIOUR
//  - Reset (rst==0 at posedge) gives state=IDLE, window=0, cnt=0.
//    Outputs while in reset: blk_ready=0, w_valid=0, w_data=0, w_idx=0,
//    w_last=0, busy=0. blk_ready goes to 1 on the first clock with rst==1.
//  - FSM IDLE: blk_ready=1, w_valid=0.
//    * On blk_valid&&blk_ready: load win[0..15] from blk_data, set cnt=0,
//      go to RUN.
//    * W[0] appears on w_data with w_valid=1 on the next cycle
//      (latency 1 clock).
//  - FSM RUN: blk_ready=0, w_valid=1, w_data=win[0], w_idx=cnt.
//    * On w_valid&&w_ready: shift the window, win[i]=win[i+1] for i<15.
//      Set win[15]=s1(win[14])+win[9]+s0(win[1])+win[0] mod 2^32, then cnt++.
//    * s0(x) = ROTR7 ^ ROTR18 ^ SHR3.  s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
//    * Words 0..15 are the raw block words. Words 16+ are the recurrence result.
//  - Handshake on w_last: go to IDLE. blk_ready=1 on the following cycle.
//    No back-to-back block overlap.
//  - Backpressure: while w_ready=0, w_data, w_idx, w_last and window hold stable.
//  - blk_valid in RUN is ignored (blk_ready=0), and the block is not latched.
//  - Reset mid-RUN aborts the block. Outputs return to reset values, and no
//    partial words are emitted afterwards.
//  - cnt never wraps. ROUNDS-1 is terminal, and cnt clears on the next block load.
//  - All additions use 32-bit wrap-around. Carries are discarded.
// CONFIGURATION
//  MSG_SCHED_BYTESWAP_EN
//   - Defined: every 32-bit input word is byte-reversed on load,
//     {b0,b1,b2,b3} -> {b3,b2,b1,b0}. This is for raw little-endian Bitcoin
//     header fields.
//   - Undefined: words are loaded as-is, big-endian per FIPS 180-4.
//     This is the default.
//   - The recurrence and outputs are otherwise identical.
// TESTING
//  T1 "abc" block: 61626380, 13x00000000, 00000018 -> W0=61626380,
//     W15=00000018, W16=61626380, W17=000F0000, W18=7DA86405, W19=600003C6.
//  T2 all-zero block, w_ready=1 -> 64 words of 00000000. w_last only at
//     w_idx=63. blk_ready=1 exactly one cycle after the last handshake.
//  T3 "abc" block, w_ready held low 5 cycles at w_idx=20 -> w_data/w_idx stable.
//     Resume gives W20=3E9D7B78, then W21=0183FC00.
//  T4 rst=0 for 1 clock at w_idx=30 -> next cycle w_valid=0, busy=0,
//     blk_ready=0. New block afterwards restarts at w_idx=0 with correct W0.
//  T5 blk_valid pulsed with a different block at w_idx=10 -> ignored.
//     Sequence still matches the T1 golden model. busy stays high.
//  T6 MSG_SCHED_BYTESWAP_EN defined, word0=80636261, rest as T1 -> W0=61626380.

Source files
------------

// File: rtl/msg_schedule_gen.sv
// msg_schedule_gen: SHA-256 message-schedule stage.
// Takes one 512-bit padded block and streams W[0..ROUNDS-1] over a
// valid/ready handshake, built on a 16-word sliding window.
// Optional build macro: MSG_SCHED_BYTESWAP_EN byte-reverses each input word
// on load (for raw little-endian header fields); default loads big-endian.
module msg_schedule_gen #(
  parameter int ROUNDS  = 64,
  parameter int BLOCK_W = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLOCK_W-1:0] blk_data,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [31:0]        w_data,
  output logic [5:0]         w_idx,
  output logic               w_last,
  output logic               busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] win_reg  [16];
  logic [31:0] win_next [16];
  logic [5:0]  cnt_reg, cnt_next;
  logic        init_reg;
  logic [31:0] load_word [16];
  logic [31:0] w_new;
  logic        is_last;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Split the block into 16 words, word 0 in the top bits.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_load
      logic [31:0] raw;
      assign raw = blk_data[BLOCK_W-1-32*gi -: 32];
`ifdef MSG_SCHED_BYTESWAP_EN
      assign load_word[gi] = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
`else
      assign load_word[gi] = raw;
`endif
    end
  endgenerate

  // Next schedule word from the current window (all adds wrap mod 2^32).
  assign w_new   = sig1(win_reg[14]) + win_reg[9] + sig0(win_reg[1]) + win_reg[0];
  assign is_last = (cnt_reg == 6'(ROUNDS - 1));
  assign w_idx   = cnt_reg;

  // Next-state, window update and handshake outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    win_next   = win_reg;
    blk_ready  = 1'b0;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    busy       = 1'b0;
    w_data     = 32'h0;
    case (state_reg)
      IDLE: begin
        // init_reg keeps blk_ready low for the first cycle out of reset.
        blk_ready = init_reg;
        if (blk_valid && init_reg) begin
          win_next   = load_word;
          cnt_next   = 6'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        w_data  = win_reg[0];
        w_last  = is_last;
        if (w_ready) begin
          for (int i = 0; i < 15; i++) win_next[i] = win_reg[i+1];
          win_next[15] = w_new;
          if (is_last) state_next = IDLE;
          else         cnt_next   = cnt_reg + 6'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter and window registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
      init_reg  <= 1'b0;
      for (int i = 0; i < 16; i++) win_reg[i] <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      init_reg  <= 1'b1;
      win_reg   <= win_next;
    end
  end

endmodule
